// File: rtl/hazard_pkg.sv
// Shared definitions for the register hazard scoreboard: FSM states,
// pending-count width, register-file size and the effective-busy helper.
package hazard_pkg;

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FCNT_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

    // A register is still unsafe to read if writes remain pending after
    // discounting the one landing in the register file this cycle.
    function automatic logic eff_busy(input logic [CNT_W-1:0] cnt, input logic wb_hit);
        return (cnt > CNT_W'(1)) || ((cnt == CNT_W'(1)) && !wb_hit);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: 2-bit saturating up/down counter.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   inc, dec   - increment / decrement requests (both together cancel)
//   count      - registered pending count
//   err_c      - combinational pulse when an inc/dec hits saturation
module sb_counter
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err_c
);

    logic [CNT_W-1:0] count_nxt;

    // Saturating next-count; saturation is flagged instead of wrapping.
    always_comb begin
        count_nxt = count;
        err_c     = 1'b0;
        if (inc && !dec) begin
            if (count == CNT_MAX) err_c = 1'b1;
            else                  count_nxt = count + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count == '0)      err_c = 1'b1;
            else                  count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_nxt;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for a 5-stage pipeline: tracks pending writes
// per register, stalls ID on read-after-write hazards and squashes issue
// after a taken branch.
// Optional feature macro: HAZARD_STATS_EN adds stall_cnt / flush_cnt.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   src1_id, src2_id       - source registers of the instruction in ID
//   src2_used_id           - src2 is actually read
//   dest_id, wb_en_id      - destination / write enable of the ID instruction
//   dest_wb, wb_en_wb      - register-file write this cycle
//   branch_taken_exe       - taken branch resolved in EXE
//   freeze, bubble, flush_if - pipeline control (combinational)
//   busy_vec               - registers with pending writes
//   sb_err                 - sticky counter saturation flag
//   stall_cnt, flush_cnt   - (HAZARD_STATS_EN) saturating event counters
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] src1_id,
    input  logic [REG_IDX_W-1:0] src2_id,
    input  logic                 src2_used_id,
    input  logic [REG_IDX_W-1:0] dest_id,
    input  logic                 wb_en_id,
    input  logic [REG_IDX_W-1:0] dest_wb,
    input  logic                 wb_en_wb,
    input  logic                 branch_taken_exe,
    output logic                 freeze,
    output logic                 bubble,
    output logic                 flush_if,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 sb_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    fsm_state_t          state, next_state;
    logic [FCNT_W-1:0]   fcnt, fcnt_nxt;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0] inc_v, dec_v, err_v, eff_v;
    logic                issue;
    logic                hazard;

    assign issue = !rst && !freeze && !bubble;

    // Register 0 is hardwired: never counted, never busy.
    assign cnt[0]   = '0;
    assign inc_v[0] = 1'b0;
    assign dec_v[0] = 1'b0;
    assign err_v[0] = 1'b0;
    assign eff_v[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic wb_hit;
        assign wb_hit   = wb_en_wb && (dest_wb == REG_IDX_W'(r));
        assign inc_v[r] = issue && wb_en_id && (dest_id == REG_IDX_W'(r));
        assign dec_v[r] = !rst && wb_hit;
        assign eff_v[r] = eff_busy(cnt[r], wb_hit);

        sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_v[r]),
            .dec   (dec_v[r]),
            .count (cnt[r]),
            .err_c (err_v[r])
        );
    end

    assign hazard = eff_v[src1_id] || (src2_used_id && eff_v[src2_id]);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = !rst && (cnt[i] != '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= next_state;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next state: fcnt holds FLUSH cycles still to come; the branch cycle
    // itself is the first squashed cycle, so a 1-cycle flush never enters FLUSH.
    always_comb begin
        next_state = state;
        fcnt_nxt   = fcnt;
        if (branch_taken_exe) begin
            fcnt_nxt   = FCNT_W'(FLUSH_CYCLES - 1);
            next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            fcnt_nxt = fcnt - FCNT_W'(1);
            if (fcnt == FCNT_W'(1)) next_state = RUN;
        end
    end

    // Outputs: branch squash has priority over hazard stall.
    always_comb begin
        freeze   = 1'b0;
        bubble   = 1'b0;
        flush_if = 1'b0;
        if (!rst) begin
            if (branch_taken_exe || (state == FLUSH)) begin
                flush_if = 1'b1;
                bubble   = 1'b1;
            end else begin
                freeze = hazard;
                bubble = hazard;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         sb_err <= 1'b0;
        else if (|err_v) sb_err <= 1'b1;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
            if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3: number of cycles ID issue is squashed after a taken branch.
REQ-002 SHALL have ports clk (in, 1): the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst (in, 1): reset, synchronous and active-high.
REQ-004 SHALL have port src1_id (in, 5): instruction[25:21] of the instruction in ID.
REQ-005 SHALL have port src2_id (in, 5): instruction[20:16] of the instruction in ID.
REQ-006 SHALL have port src2_used_id (in, 1): src2 is read (register-form ALU, ST, BNE).
REQ-007 SHALL have ports dest_id (in, 5) and wb_en_id (in, 1): destination and write enable of the instruction in ID.
REQ-008 SHALL have ports dest_wb (in, 5) and wb_en_wb (in, 1): register-file write this cycle.
REQ-009 SHALL have port branch_taken_exe (in, 1): branch resolved taken in EXE.
REQ-010 SHALL have port freeze (out, 1): hold PC and IF/ID register.
REQ-011 SHALL have port bubble (out, 1): load zero controls into ID/EX (flush input of the ID/EX register).
REQ-012 SHALL have port flush_if (out, 1): clear IF/ID register.
REQ-013 SHALL have port busy_vec (out, 32): bit r set when register r has a pending write.
REQ-014 SHALL have port sb_err (out, 1): sticky pending-count overflow/underflow flag.

Function
REQ-015 SHALL keep a 2-bit pending count per register 1..31; register 0 is never counted and never causes a hazard.
REQ-016 SHALL define issue = !rst && !freeze && !bubble; on issue with wb_en_id and dest_id!=0, count[dest_id] increments.
REQ-017 SHALL decrement count[dest_wb] when wb_en_wb and dest_wb!=0; simultaneous increment and decrement of the same register leave it unchanged.
REQ-018 SHALL compute effective count = count minus 1 when that register is being written back this cycle (register file writes on negedge, so WB-stage results are readable).
REQ-019 SHALL assert hazard combinationally when effective count of src1_id !=0, or src2_used_id and effective count of src2_id !=0.
REQ-020 SHALL use states RUN, FLUSH; RUN->FLUSH on branch_taken_exe loading a flush counter with FLUSH_CYCLES-1; FLUSH decrements, returns to RUN at 0; branch_taken_exe in FLUSH reloads the counter.
REQ-021 SHALL, in the cycle branch_taken_exe is high or while in FLUSH, drive flush_if=1, bubble=1, freeze=0.
REQ-022 SHALL otherwise drive freeze=hazard, bubble=hazard, flush_if=0; branch/flush has priority over hazard.
REQ-023 SHALL have zero-cycle latency on freeze, bubble, flush_if (combinational from inputs and state); busy_vec reflects registered counts.
REQ-024 SHALL saturate a count at 3 on increment and at 0 on decrement, setting sb_err in either case; sb_err clears only on rst.

Reset
REQ-025 SHALL, on rst, clear all counts, flush counter and sb_err, and enter RUN; while rst is high freeze=0, bubble=0, flush_if=0, busy_vec=0.
REQ-026 SHALL discard in-flight state on reset mid-operation; writebacks during rst are ignored.

Configuration
REQ-027 SHALL, with HAZARD_STATS_EN defined, add outputs stall_cnt (32) and flush_cnt (32), counting cycles with freeze=1 and flush_if=1 respectively, saturating at all-ones, cleared on rst.
REQ-028 SHALL, without HAZARD_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place the state enum (RUN, FLUSH), count width (2) and register-count constant (32) in shared package hazard_pkg.
REQ-030 SHALL implement one sub-module sb_counter (per-register 2-bit saturating up/down counter with error output), instantiated 31 times.

Verification
REQ-031 SHALL test RAW stall: issue ADD dest=5, next instr src1=5 -> freeze=1, bubble=1 until WB of r5, no stall in the WB cycle.
REQ-032 SHALL test immediate: ADDI dest=4 in flight, next src2_id=4 with src2_used_id=0 -> freeze=0.
REQ-033 SHALL test branch: branch_taken_exe=1 with hazard also present, FLUSH_CYCLES=2 -> flush_if=1, bubble=1, freeze=0 for 2 cycles, no count increment.
REQ-034 SHALL test same-cycle inc/dec on r7 with count 1 -> count stays 1, busy_vec[7]=1.
REQ-035 SHALL test r0: wb_en_id=1, dest_id=0, next src1=0 -> busy_vec=0, freeze=0.
REQ-036 SHALL test overflow: four issues to r3 with no writeback -> count 3, sb_err=1; then rst -> busy_vec=0, sb_err=0.
